// File: rtl/us_arp_rx.sv
// -----------------------------------------------------------------------------
// us_arp_rx
// ARP receive parser for the 10G UDP stack. Consumes 64-bit AXI-Stream
// Ethernet frames, validates ARP packets addressed to this host and reports
// each accepted request/reply with a one-cycle pulse plus the sender MAC/IP.
//
// Ports
//   rx_axis_aclk        clock
//   rx_axis_aresetn     asynchronous active-low reset
//   arp_rx_axis_*       AXI-Stream sink (tdata/tkeep/tvalid/tlast, tready out)
//   local_mac_addr      own MAC (quasi-static)
//   local_ip_addr       own IP (quasi-static)
//   recv_src_mac_addr   SHA of the last accepted ARP packet
//   recv_src_ip_addr    SPA of the last accepted ARP packet
//   arp_request_valid   pulse: accepted request (OPER=1)
//   arp_reply_valid     pulse: accepted reply (OPER=2)
//   arp_rx_error        pulse: malformed ARP frame
// -----------------------------------------------------------------------------
module us_arp_rx (
    input  logic        rx_axis_aclk,
    input  logic        rx_axis_aresetn,
    input  logic [63:0] arp_rx_axis_tdata,
    input  logic [7:0]  arp_rx_axis_tkeep,
    input  logic        arp_rx_axis_tvalid,
    input  logic        arp_rx_axis_tlast,
    output logic        arp_rx_axis_tready,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    output logic [47:0] recv_src_mac_addr,
    output logic [31:0] recv_src_ip_addr,
    output logic        arp_request_valid,
    output logic        arp_reply_valid,
    output logic        arp_rx_error
);

    typedef enum logic [1:0] {
        ST_PARSE = 2'd0,
        ST_TAIL  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [31:0] tpa_q, tpa_d;
    logic        is_req_q, is_req_d;
    logic        hdr_bad_q, hdr_bad_d;
    logic        tready_q, tready_d;
    logic        req_q, req_d;
    logic        rep_q, rep_d;
    logic        err_q, err_d;
    logic [47:0] recv_mac_q, recv_mac_d;
    logic [31:0] recv_ip_q, recv_ip_d;

    // Only tkeep[1:0] on beat 5 matters; the remaining enables are don't-care.
    logic unused_keep;
    assign unused_keep = ^arp_rx_axis_tkeep[7:2];

    // Byte i of the current beat.
    logic [7:0] b [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
            assign b[gi] = arp_rx_axis_tdata[8*gi +: 8];
        end
    endgenerate

    logic        beat;
    logic [47:0] da;
    logic [15:0] w01, w45, w67;
    logic        early_rej;
    logic        bad_now;
    logic        truncated;

    assign beat = arp_rx_axis_tvalid & tready_q;
    assign da   = {b[0], b[1], b[2], b[3], b[4], b[5]};
    assign w01  = {b[0], b[1]};
    assign w45  = {b[4], b[5]};   // ethertype on beat 1, OPER on beat 2
    assign w67  = {b[6], b[7]};   // HTYPE on beat 1

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tpa_d      = tpa_q;
        is_req_d   = is_req_q;
        hdr_bad_d  = hdr_bad_q;
        tready_d   = 1'b1;
        req_d      = 1'b0;
        rep_d      = 1'b0;
        err_d      = 1'b0;
        recv_mac_d = recv_mac_q;
        recv_ip_d  = recv_ip_q;
        early_rej  = 1'b0;
        bad_now    = hdr_bad_q;
        truncated  = 1'b0;

        if (beat) begin
            if (state_q == ST_PARSE) begin
                case (beat_cnt_q)
                    3'd0: early_rej = (da != local_mac_addr) && (da != 48'hFFFF_FFFF_FFFF);
                    3'd1: begin
                        early_rej = (w45 != 16'h0806);
                        bad_now   = bad_now | (w67 != 16'h0001);
                    end
                    3'd2: begin
                        bad_now = bad_now | (w01 != 16'h0800) | (b[2] != 8'd6) |
                                  (b[3] != 8'd4) | ((w45 != 16'd1) && (w45 != 16'd2));
                        is_req_d      = (w45 == 16'd1);
                        sha_d[47:32]  = {b[6], b[7]};
                    end
                    3'd3: begin
                        sha_d[31:0] = {b[0], b[1], b[2], b[3]};
                        spa_d       = {b[4], b[5], b[6], b[7]};
                    end
                    3'd4: tpa_d[31:16] = {b[6], b[7]};
                    3'd5: begin
                        tpa_d[15:0] = {b[0], b[1]};
                        // TPA's last two bytes must actually be present.
                        truncated   = arp_rx_axis_tlast && (arp_rx_axis_tkeep[1:0] != 2'b11);
                    end
                    default: ;
                endcase
                if (arp_rx_axis_tlast && (beat_cnt_q < 3'd5)) begin
                    truncated = 1'b1;
                end
                if (early_rej) begin
                    state_d = ST_DROP;
                end else if (beat_cnt_q == 3'd5) begin
                    state_d = ST_TAIL;
                end
            end

            beat_cnt_d = (beat_cnt_q == 3'd6) ? 3'd6 : beat_cnt_q + 3'd1;
            hdr_bad_d  = bad_now;

            // Single decision point per frame; uses the values just captured.
            if (arp_rx_axis_tlast) begin
                state_d    = ST_PARSE;
                beat_cnt_d = 3'd0;
                hdr_bad_d  = 1'b0;
                if ((state_q != ST_DROP) && !early_rej) begin
                    if (truncated || bad_now) begin
                        err_d = 1'b1;
                    end else if (tpa_d == local_ip_addr) begin
                        req_d      = is_req_d;
                        rep_d      = ~is_req_d;
                        recv_mac_d = sha_d;
                        recv_ip_d  = spa_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            state_q    <= ST_PARSE;
            beat_cnt_q <= 3'd0;
            sha_q      <= '0;
            spa_q      <= '0;
            tpa_q      <= '0;
            is_req_q   <= 1'b0;
            hdr_bad_q  <= 1'b0;
            tready_q   <= 1'b0;
            req_q      <= 1'b0;
            rep_q      <= 1'b0;
            err_q      <= 1'b0;
            recv_mac_q <= '0;
            recv_ip_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            tpa_q      <= tpa_d;
            is_req_q   <= is_req_d;
            hdr_bad_q  <= hdr_bad_d;
            tready_q   <= tready_d;
            req_q      <= req_d;
            rep_q      <= rep_d;
            err_q      <= err_d;
            recv_mac_q <= recv_mac_d;
            recv_ip_q  <= recv_ip_d;
        end
    end

    assign arp_rx_axis_tready = tready_q;
    assign arp_request_valid  = req_q;
    assign arp_reply_valid    = rep_q;
    assign arp_rx_error       = err_q;
    assign recv_src_mac_addr  = recv_mac_q;
    assign recv_src_ip_addr   = recv_ip_q;

endmodule

// File: tb/tb_us_arp_rx.sv
// -----------------------------------------------------------------------------
// tb_us_arp_rx
// Bench for us_arp_rx: directed scenarios followed by randomized frames, each
// outcome predicted by a byte-offset reference model of the ARP rules.
// -----------------------------------------------------------------------------
module tb_us_arp_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [47:0] lmac;
    logic [31:0] lip;
    logic [47:0] rmac;
    logic [31:0] rip;
    logic        req;
    logic        rep;
    logic        err;

    always #5 clk = ~clk;

    us_arp_rx dut (
        .rx_axis_aclk       (clk),
        .rx_axis_aresetn    (rst_n),
        .arp_rx_axis_tdata  (tdata),
        .arp_rx_axis_tkeep  (tkeep),
        .arp_rx_axis_tvalid (tvalid),
        .arp_rx_axis_tlast  (tlast),
        .arp_rx_axis_tready (tready),
        .local_mac_addr     (lmac),
        .local_ip_addr      (lip),
        .recv_src_mac_addr  (rmac),
        .recv_src_ip_addr   (rip),
        .arp_request_valid  (req),
        .arp_reply_valid    (rep),
        .arp_rx_error       (err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_cyc = 0;
    int pulse_cyc = 0;
    int nframe = 0;
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
    logic        exp_tready;
    logic [47:0] m_sha;
    logic [31:0] m_spa;
    byte unsigned frm[$];

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (frame %0d, cycle %0d)", tag, obs, expv, nframe, cyc);
        end
    endtask

    // res: 0 nothing, 1 request, 2 reply, 3 error
    task automatic check_outputs(input int res);
        chk("tready", {63'd0, tready}, {63'd0, exp_tready});
        chk("req_pulse", {63'd0, req}, {63'd0, res == 1});
        chk("rep_pulse", {63'd0, rep}, {63'd0, res == 2});
        chk("err_pulse", {63'd0, err}, {63'd0, res == 3});
        chk("recv_mac", {16'd0, rmac}, {16'd0, exp_mac});
        chk("recv_ip", {32'd0, rip}, {32'd0, exp_ip});
    endtask

    task automatic step(input int res);
        @(posedge clk);
        #1;
        cyc++;
        if (res == 1 || res == 2) begin
            exp_mac = m_sha;
            exp_ip  = m_spa;
        end
        if (req || rep || err) pulse_cyc = cyc;
        check_outputs(res);
    endtask

    // Big-endian field read from the frame bytes.
    function automatic logic [63:0] getf(input int off, input int nb);
        logic [63:0] v = '0;
        for (int k = 0; k < nb; k++) v = {v[55:0], frm[off + k]};
        return v;
    endfunction

    task automatic put(input int off, input int nb, input logic [63:0] v);
        for (int k = 0; k < nb; k++)
            if (off + k < frm.size()) frm[off + k] = v[8*(nb-1-k) +: 8];
    endtask

    // Reference model: the ARP acceptance rules applied to the whole frame.
    task automatic run_model(output int res);
        int n = frm.size();
        logic [63:0] oper;
        res = 0;
        if (getf(0, 6) != {16'd0, lmac} && getf(0, 6) != {16'd0, BCAST}) return;
        if (n <= 8) begin res = 3; return; end
        if (getf(12, 2) != 64'h0806) return;
        if (n < 42) begin res = 3; return; end
        oper = getf(20, 2);
        if (getf(14, 2) != 64'h0001 || getf(16, 2) != 64'h0800 || getf(18, 1) != 64'd6 ||
            getf(19, 1) != 64'd4 || !(oper == 64'd1 || oper == 64'd2)) begin
            res = 3;
            return;
        end
        if (getf(38, 4) != {32'd0, lip}) return;
        m_sha = getf(22, 6)[47:0];
        m_spa = getf(28, 4)[31:0];
        res   = int'(oper);
    endtask

    task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] htype,
                         input logic [15:0] ptype, input logic [7:0] hlen, input logic [7:0] plen,
                         input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [31:0] tpa, input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        put(0, 6, {16'd0, da});
        put(6, 6, 64'h0000_0211_2233_4455);
        put(12, 2, {48'd0, et});
        put(14, 2, {48'd0, htype});
        put(16, 2, {48'd0, ptype});
        put(18, 1, {56'd0, hlen});
        put(19, 1, {56'd0, plen});
        put(20, 2, {48'd0, oper});
        put(22, 6, {16'd0, sha});
        put(28, 4, {32'd0, spa});
        put(32, 6, 64'd0);
        put(38, 4, {32'd0, tpa});
    endtask

    // gap_mode: 0 none, 1 idle between every beat, 2 random idles.
    // abort_after >= 0 stops after that many beats (no tlast).
    task automatic send_frame(input int gap_mode, input int abort_after);
        int n  = frm.size();
        int nb = (n + 7) / 8;
        int res;
        int g;
        run_model(res);
        nframe++;
        for (int bi = 0; bi < nb; bi++) begin
            if (abort_after >= 0 && bi == abort_after) begin
                tvalid = 1'b0;
                return;
            end
            g = 0;
            if (gap_mode == 1 && bi > 0) g = 1;
            if (gap_mode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
            for (int k = 0; k < g; k++) begin
                tvalid = 1'b0;
                tdata  = {$urandom, $urandom};
                tlast  = 1'($urandom);
                tkeep  = 8'($urandom);
                step(0);
            end
            tvalid = 1'b1;
            tlast  = (bi == nb - 1);
            for (int k = 0; k < 8; k++) begin
                if (bi * 8 + k < n) begin
                    tdata[8*k +: 8] = frm[bi * 8 + k];
                    tkeep[k] = 1'b1;
                end else begin
                    tdata[8*k +: 8] = 8'($urandom);
                    tkeep[k] = 1'b0;
                end
            end
            if (bi == 0) first_cyc = cyc;
            step((bi == nb - 1) ? res : 0);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        int lens[11] = '{16, 24, 30, 40, 41, 42, 46, 48, 60, 64, 90};
        logic [47:0] da;
        logic [15:0] et, ht, pt, op;
        logic [7:0]  hl, pl;
        logic [31:0] tpa;
        int r;

        rst_n  = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        tkeep  = '0;
        lmac   = 48'hab10_2027_55fc;
        lip    = 32'hC0A8_010B;
        exp_mac = '0;
        exp_ip  = '0;
        exp_tready = 1'b0;

        // Reset state
        repeat (3) step(0);
        rst_n = 1'b1;
        #1;
        check_outputs(0);
        exp_tready = 1'b1;
        step(0);

        // 1: broadcast request
        build(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'hac00_0124_25bc, 32'hC0A8_010A, 32'hC0A8_010B, 60);
        send_frame(0, -1);
        chk("s1_req", {63'd0, req}, 64'd1);
        chk("s1_mac", {16'd0, rmac}, 64'h0000_ac00_0124_25bc);
        chk("s1_ip", {32'd0, rip}, 64'hC0A8_010A);
        step(0);

        // 2: unicast reply
        build(lmac, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2,
              48'h0a0b_0c0d_0e0f, 32'hC0A8_0114, lip, 60);
        send_frame(0, -1);
        chk("s2_rep", {63'd0, rep}, 64'd1);
        chk("s2_noreq", {63'd0, req}, 64'd0);
        chk("s2_ip", {32'd0, rip}, 64'hC0A8_0114);

        // 3: wrong TPA, then IPv4 ethertype
        build(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'h1111_2222_3333, 32'hC0A8_0105, 32'hC0A8_010C, 60);
        send_frame(2, -1);
        build(lmac, 16'h0800, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'h1111_2222_3333, 32'hC0A8_0105, lip, 60);
        send_frame(0, -1);
        step(0);
        chk("s3_ip_kept", {32'd0, rip}, 64'hC0A8_0114);

        // 4: truncated at beat 3, then back-to-back valid request
        build(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'hac00_0124_25bc, 32'hC0A8_010A, lip, 32);
        send_frame(0, -1);
        chk("s4_err", {63'd0, err}, 64'd1);
        build(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'hac00_0124_25bc, 32'hC0A8_010A, lip, 42);
        send_frame(0, -1);
        chk("s4_req", {63'd0, req}, 64'd1);
        chk("s4_latency", 64'(pulse_cyc - first_cyc), 64'd6);

        // 5: HLEN=8
        build(lmac, 16'h0806, 16'h0001, 16'h0800, 8'd8, 8'd4, 16'd1,
              48'h9999_8888_7777, 32'hC0A8_0199, lip, 60);
        send_frame(0, -1);
        chk("s5_err", {63'd0, err}, 64'd1);
        chk("s5_ip_kept", {32'd0, rip}, 64'hC0A8_010A);
        step(0);

        // 6: request with tvalid toggling
        build(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1,
              48'hac00_0124_25bc, 32'hC0A8_010A, lip, 60);
        send_frame(1, -1);
        chk("s6_req", {63'd0, req}, 64'd1);
        chk("s6_mac", {16'd0, rmac}, 64'h0000_ac00_0124_25bc);
        step(0);

        // Reset mid-frame
        build(lmac, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2,
              48'h5555_6666_7777, 32'hC0A8_0150, lip, 60);
        send_frame(0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_mac = '0;
        exp_ip  = '0;
        exp_tready = 1'b0;
        check_outputs(0);
        repeat (2) step(0);
        rst_n = 1'b1;
        #1;
        check_outputs(0);
        exp_tready = 1'b1;
        step(0);
        build(lmac, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2,
              48'h5555_6666_7777, 32'hC0A8_0150, lip, 60);
        send_frame(0, -1);
        chk("rst_rep", {63'd0, rep}, 64'd1);

        // Randomized frames
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            da = (r < 6) ? lmac : (r < 9) ? BCAST : {$urandom, 16'($urandom)};
            et = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h0806;
            ht = ($urandom_range(0, 14) == 0) ? 16'h0006 : 16'h0001;
            pt = ($urandom_range(0, 14) == 0) ? 16'h86DD : 16'h0800;
            hl = ($urandom_range(0, 14) == 0) ? 8'd8 : 8'd6;
            pl = ($urandom_range(0, 14) == 0) ? 8'd16 : 8'd4;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 16'd1 : (r < 8) ? 16'd2 : (r == 8) ? 16'd3 : 16'd0;
            tpa = ($urandom_range(0, 4) == 0) ? $urandom : lip;
            build(da, et, ht, pt, hl, pl, op, {$urandom, 16'($urandom)}, $urandom, tpa,
                  lens[$urandom_range(0, 10)]);
            send_frame($urandom_range(0, 1) * 2, -1);
            if ($urandom_range(0, 19) == 0) begin
                step(0);
                lip  = 32'hC0A8_0100 | 32'($urandom_range(1, 254));
                lmac = {$urandom, 16'($urandom)};
            end
        end
        repeat (3) step(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
